// File: rtl/fifo_write_driver.sv
// -----------------------------------------------------------------------------
// fifo_write_driver
//
// Initiator for the write_req / left_sig FIFO interface of the arithmetic
// *_interface blocks. Words from an upstream source are buffered in a small
// circular queue. They are then written downstream, but only while the
// downstream free-slot count (left_sig_i) leaves room for every write that is
// still in flight.
//
// Handshakes:
//   upstream   : a word is taken on a rising edge where in_valid_i and
//                in_ready_o are both 1. in_ready_o depends only on registers.
//   downstream : write_req_o is a registered one-cycle strobe per word, and
//                fifo_write_data_o carries the word in that cycle. The
//                downstream accepts the word at the end of that cycle and
//                shows the effect on left_sig_i two cycles later.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid_i         upstream word valid
//   in_data_i          upstream word
//   in_ready_o         local queue has room (count < BUF_DEPTH)
//   left_sig_i         downstream free entries (registered downstream)
//   write_req_o        downstream write strobe, registered
//   fifo_write_data_o  downstream write data, valid while write_req_o = 1
//   busy_o             queue non-empty or a write still in flight
//   stall_sig_o        queue non-empty but no credit (FSM in WAIT)
//   sent_count_o       writes issued since reset, wraps at 2^16
//   state_o            debug view of the FSM state (0 IDLE, 1 SEND, 2 WAIT)
//
// BUF_DEPTH must be a power of two and at least 2, so the pointers wrap
// naturally. LEFT_WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module fifo_write_driver #(
   parameter int DATA_WIDTH = 16,
   parameter int BUF_DEPTH  = 4,
   parameter int LEFT_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  in_ready_o,
   input  logic [LEFT_WIDTH-1:0] left_sig_i,
   output logic                  write_req_o,
   output logic [DATA_WIDTH-1:0] fifo_write_data_o,
   output logic                  busy_o,
   output logic                  stall_sig_o,
   output logic [15:0]           sent_count_o,
   output logic [1:0]            state_o
);

   localparam int PW = $clog2(BUF_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW:0]           count_q, count_d;
   logic                  write_req_q, write_req_d;
   logic                  write_req_d1_q;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [15:0]           sent_q, sent_d;

   logic                  push;
   logic                  queue_nonempty;
   logic [1:0]            inflight;
   logic                  credit_ok;
   logic                  issue;

   assign queue_nonempty = (count_q != '0);
   assign in_ready_o     = (count_q < (PW+1)'(BUF_DEPTH));
   assign push           = in_valid_i & in_ready_o;

   // Writes in the current cycle and in the previous cycle are not yet visible
   // in left_sig_i. Issue only if a slot is left after both of them.
   assign inflight  = {1'b0, write_req_q} + {1'b0, write_req_d1_q};
   assign credit_ok = ({1'b0, left_sig_i} > (LEFT_WIDTH+1)'(inflight));
   assign issue     = queue_nonempty & credit_ok;

   // Queue bookkeeping and the registered write stage. Each issue pops the
   // head into the output register in the same edge.
   always_comb begin
      wr_ptr_d    = wr_ptr_q + PW'(push);
      rd_ptr_d    = rd_ptr_q + PW'(issue);
      count_d     = count_q + (PW+1)'(push) - (PW+1)'(issue);
      write_req_d = issue;
      data_d      = data_q;
      if (issue) begin
         data_d = mem_q[rd_ptr_q];
      end
      sent_d      = sent_q + 16'(write_req_q);
   end

   // FSM next state. SEND means a write is being issued for the next cycle.
   // WAIT means words are queued but credit is short.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (queue_nonempty) begin
               state_d = issue ? ST_SEND : ST_WAIT;
            end
         end
         ST_SEND: begin
            if (issue) begin
               state_d = ST_SEND;
            end else if (queue_nonempty) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Count only drops on an issue, so WAIT always has queued words.
            if (issue) begin
               state_d = ST_SEND;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         write_req_q    <= 1'b0;
         write_req_d1_q <= 1'b0;
         data_q         <= '0;
         sent_q         <= '0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         write_req_q    <= write_req_d;
         write_req_d1_q <= write_req_q;
         data_q         <= data_d;
         sent_q         <= sent_d;
      end
   end

   // Storage needs no reset. Only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data_i;
      end
   end

   assign write_req_o       = write_req_q;
   assign fifo_write_data_o = data_q;
   assign busy_o            = queue_nonempty | write_req_q | write_req_d1_q;
   assign stall_sig_o       = (state_q == ST_WAIT);
   assign sent_count_o      = sent_q;
   assign state_o           = state_q;

endmodule
